// File: rtl/nn_fixed_pkg.sv
// Shared Q32.32 fixed-point constants, FSM state type and saturating add
// used by the neuron activation datapath.
package nn_fixed_pkg;

    localparam int          FRAC_BITS   = 32;
    localparam logic [63:0] ONE         = 64'h0000_0001_0000_0000;
    localparam logic [63:0] HALF        = 64'h0000_0000_8000_0000;

    // PLAN sigmoid breakpoints on |z|
    localparam logic [63:0] BP_1_0      = 64'h0000_0001_0000_0000;
    localparam logic [63:0] BP_2_375    = 64'h0000_0002_6000_0000;
    localparam logic [63:0] BP_5_0      = 64'h0000_0005_0000_0000;

    // PLAN segment offsets
    localparam logic [63:0] OFF_0_5     = 64'h0000_0000_8000_0000;
    localparam logic [63:0] OFF_0_625   = 64'h0000_0000_A000_0000;
    localparam logic [63:0] OFF_0_84375 = 64'h0000_0000_D800_0000;

    localparam logic [63:0] SAT_MAX     = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] SAT_MIN     = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SIG   = 2'd2,
        ST_DONE  = 2'd3
    } nau_state_e;

    // Signed 64-bit add that clamps to SAT_MAX/SAT_MIN instead of wrapping.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        s = {a[63], a} + {b[63], b};
        if (s[64] != s[63])
            return s[64] ? SAT_MIN : SAT_MAX;
        return s[63:0];
    endfunction

endpackage

// File: rtl/neuron_activation_unit_if.sv
// Job, beat-stream and result signals between the forward-propagation
// sequencer (master) and the neuron activation unit (slave).
interface neuron_activation_unit_if #(
    parameter int IDX_W = 8
);
    import nn_fixed_pkg::*;

    // Beat handshake: a beat transfers on a rising edge where in_valid && in_ready.
    // in_ready is high only while the unit is accumulating; start is sampled in IDLE only.
    logic             start;
    logic [IDX_W-1:0] layer_idx;
    logic [IDX_W-1:0] neuron_idx;
    logic [63:0]      bias;
    logic             in_valid;
    logic [31:0]      x_in;
    logic [31:0]      w_in;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [63:0]      act_out;
    logic [63:0]      sig_out;
    logic [IDX_W-1:0] out_layer;
    logic [IDX_W-1:0] out_neuron;
    nau_state_e       state_dbg;

    modport master (
        output start, layer_idx, neuron_idx, bias, in_valid, x_in, w_in,
        input  in_ready, busy, done, act_out, sig_out, out_layer, out_neuron, state_dbg
    );

    modport slave (
        input  start, layer_idx, neuron_idx, bias, in_valid, x_in, w_in,
        output in_ready, busy, done, act_out, sig_out, out_layer, out_neuron, state_dbg
    );

endinterface

// File: rtl/neuron_activation_unit_sigmoid_plan.sv
// Combinational piecewise-linear (PLAN) sigmoid: signed Q32.32 in,
// unsigned Q32.32 out in [0, 1].
module sigmoid_plan
    import nn_fixed_pkg::*;
(
    input  logic [63:0] z,
    output logic [63:0] sig
);

    logic [63:0] a;
    logic [63:0] y;

    always_comb begin
        // The most negative value has no positive twin; clamp its magnitude.
        if (!z[63])
            a = z;
        else if (z == SAT_MIN)
            a = SAT_MAX;
        else
            a = -z;

        if (a >= BP_5_0)
            y = ONE;
        else if (a >= BP_2_375)
            y = (a >> 5) + OFF_0_84375;
        else if (a >= BP_1_0)
            y = (a >> 3) + OFF_0_625;
        else
            y = (a >> 2) + OFF_0_5;

        sig = z[63] ? (ONE - y) : y;
    end

endmodule

// File: rtl/neuron_activation_unit.sv
// Single-neuron engine: bias-seeded saturating MAC over N_INPUTS beats,
// then a registered PLAN sigmoid of the sum.
module neuron_activation_unit
    import nn_fixed_pkg::*;
#(
    parameter int N_INPUTS = 10,
    parameter int IDX_W    = 8
) (
    input logic                  clk,
    input logic                  rst,
    neuron_activation_unit_if.slave bus
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

    nau_state_e       state;
    logic [63:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] layer_q;
    logic [IDX_W-1:0] neuron_q;
    logic [63:0]      act_q;
    logic [63:0]      sig_q;
    logic [IDX_W-1:0] out_layer_q;
    logic [IDX_W-1:0] out_neuron_q;
    logic             done_q;
    logic             busy_q;
    logic             in_ready_q;

    logic [63:0] prod;
    logic [63:0] sig_c;

    // Q16.16 x Q16.16 gives an exact Q32.32 product in 64 bits.
    assign prod = $signed({{32{bus.x_in[31]}}, bus.x_in}) * $signed({{32{bus.w_in[31]}}, bus.w_in});

    sigmoid_plan u_sigmoid (
        .z   (acc),
        .sig (sig_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            acc          <= '0;
            cnt          <= '0;
            layer_q      <= '0;
            neuron_q     <= '0;
            act_q        <= '0;
            sig_q        <= '0;
            out_layer_q  <= '0;
            out_neuron_q <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        layer_q    <= bus.layer_idx;
                        neuron_q   <= bus.neuron_idx;
                        acc        <= bus.bias;
                        cnt        <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        state      <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (bus.in_valid && in_ready_q) begin
                        acc <= sat_add(acc, prod);
                        if (cnt == LAST_BEAT) begin
                            in_ready_q <= 1'b0;
                            state      <= ST_SIG;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_SIG: begin
                    act_q        <= acc;
                    sig_q        <= sig_c;
                    out_layer_q  <= layer_q;
                    out_neuron_q <= neuron_q;
                    done_q       <= 1'b1;
                    state        <= ST_DONE;
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.act_out    = act_q;
    assign bus.sig_out    = sig_q;
    assign bus.out_layer  = out_layer_q;
    assign bus.out_neuron = out_neuron_q;
    assign bus.state_dbg  = state;

endmodule

// File: tb/tb_neuron_activation_unit.sv
// Directed scoreboard bench for neuron_activation_unit with two beats per job.
module tb_neuron_activation_unit;
    import nn_fixed_pkg::*;

    localparam int W = 144;  // {layer, neuron, act, sig}

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic prev_done;
    logic [W-1:0] exp_q[$];

    neuron_activation_unit_if #(.IDX_W(8)) bus ();

    neuron_activation_unit #(.N_INPUTS(2), .IDX_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every done pulse pops one expectation.
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] got;
        if (bus.done) begin
            total++;
            if (prev_done) begin
                bad++;
                $display("FAIL done_width: done high for consecutive cycles, required one");
            end
            got = {bus.out_layer, bus.out_neuron, bus.act_out, bus.sig_out};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got %h with no job expected", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL result: layer=%0d neuron=%0d act=%h sig=%h required layer=%0d neuron=%0d act=%h sig=%h",
                             got[143:136], got[135:128], got[127:64], got[63:0],
                             e[143:136], e[135:128], e[127:64], e[63:0]);
                end
            end
        end
        prev_done = bus.done;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic do_start(input logic [7:0] l, input logic [7:0] n, input logic [63:0] b);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.layer_idx  = l;
        bus.neuron_idx = n;
        bus.bias       = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] x, input logic [31:0] w, input int gap);
        int t;
        t = 0;
        repeat (gap) @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (!bus.in_ready) begin
            bad++;
            $display("FAIL in_ready_timeout: in_ready=0 required 1");
        end
        bus.in_valid = 1'b1;
        bus.x_in     = x;
        bus.w_in     = w;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (bus.busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (bus.busy) begin
            bad++;
            $display("FAIL busy_timeout: busy=1 required 0");
        end
    endtask

    task automatic run_job(input logic [7:0] l, input logic [7:0] n, input logic [63:0] b,
                           input logic [31:0] x0, input logic [31:0] w0,
                           input logic [31:0] x1, input logic [31:0] w1,
                           input int gap, input logic [63:0] ea, input logic [63:0] es);
        exp_q.push_back({l, n, ea, es});
        do_start(l, n, b);
        send_beat(x0, w0, 0);
        send_beat(x1, w1, gap);
        wait_idle();
    endtask

    logic [63:0] bias_tab [12];
    logic [63:0] sig_tab  [12];

    initial begin
        int t;
        total     = 0;
        bad       = 0;
        prev_done = 1'b0;
        bus.start = 1'b0; bus.in_valid = 1'b0;
        bus.layer_idx = '0; bus.neuron_idx = '0; bus.bias = '0;
        bus.x_in = '0; bus.w_in = '0;

        // Reset with random inputs toggling
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            bus.start    = 1'($urandom_range(0, 1));
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.bias     = {32'($urandom), 32'($urandom)};
            bus.x_in     = 32'($urandom);
            bus.w_in     = 32'($urandom);
        end
        @(negedge clk);
        check("rst_act", bus.act_out, 64'd0);
        check("rst_sig", bus.sig_out, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        bus.start = 1'b0; bus.in_valid = 1'b0;
        rst = 1'b0;

        // 1.0*0.5 + 2.0*0.25 = 1.0 -> sigmoid 0.75
        run_job(8'd1, 8'd2, 64'd0, 32'h0001_0000, 32'h0000_8000, 32'h0002_0000, 32'h0000_4000,
                0, 64'h0000_0001_0000_0000, 64'h0000_0000_C000_0000);

        // Bias-only jobs (x = 0) sweep the PLAN segments and breakpoints
        bias_tab[0]  = 64'h0000_0000_0000_0000; sig_tab[0]  = 64'h0000_0000_8000_0000;
        bias_tab[1]  = 64'hFFFF_FFFF_0000_0000; sig_tab[1]  = 64'h0000_0000_4000_0000;
        bias_tab[2]  = 64'h0000_0008_0000_0000; sig_tab[2]  = 64'h0000_0001_0000_0000;
        bias_tab[3]  = 64'hFFFF_FFF8_0000_0000; sig_tab[3]  = 64'h0000_0000_0000_0000;
        bias_tab[4]  = 64'h0000_0003_0000_0000; sig_tab[4]  = 64'h0000_0000_F000_0000;
        bias_tab[5]  = 64'hFFFF_FFFD_0000_0000; sig_tab[5]  = 64'h0000_0000_1000_0000;
        bias_tab[6]  = 64'h0000_0002_6000_0000; sig_tab[6]  = 64'h0000_0000_EB00_0000;
        bias_tab[7]  = 64'h0000_0002_5FFF_FFFF; sig_tab[7]  = 64'h0000_0000_EBFF_FFFF;
        bias_tab[8]  = 64'h0000_0005_0000_0000; sig_tab[8]  = 64'h0000_0001_0000_0000;
        bias_tab[9]  = 64'h0000_0004_FFFF_FFFF; sig_tab[9]  = 64'h0000_0000_FFFF_FFFF;
        bias_tab[10] = 64'h0000_0000_FFFF_FFFF; sig_tab[10] = 64'h0000_0000_BFFF_FFFF;
        bias_tab[11] = 64'hFFFF_FFFF_0000_0001; sig_tab[11] = 64'h0000_0000_4000_0001;
        for (int i = 0; i < 12; i++)
            run_job(8'(i + 16), 8'(i), bias_tab[i], 32'd0, 32'd0, 32'd0, 32'd0,
                    i % 3, bias_tab[i], sig_tab[i]);

        // Saturation both directions
        run_job(8'd5, 8'd5, SAT_MAX - 64'd1, 32'h0001_0000, 32'h0001_0000,
                32'h0001_0000, 32'h0001_0000, 0, SAT_MAX, ONE);
        run_job(8'd6, 8'd6, SAT_MIN + 64'd1, 32'h0001_0000, 32'hFFFF_0000,
                32'h0001_0000, 32'hFFFF_0000, 0, SAT_MIN, 64'd0);

        // Protocol: gaps, start while busy, tags 3/7
        exp_q.push_back({8'd3, 8'd7, 64'h0000_0001_0000_0000, 64'h0000_0000_C000_0000});
        do_start(8'd3, 8'd7, 64'd0);
        send_beat(32'h0001_0000, 32'h0000_8000, 1);
        do_start(8'd9, 8'd9, 64'h0000_0008_0000_0000);
        send_beat(32'h0002_0000, 32'h0000_4000, 3);
        wait_idle();

        // in_valid held in IDLE must not be accumulated
        @(negedge clk);
        bus.in_valid = 1'b1; bus.x_in = 32'h0001_0000; bus.w_in = 32'h0001_0000;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        run_job(8'd4, 8'd4, 64'd0, 32'd0, 32'h0001_0000, 32'd0, 32'h0001_0000,
                0, 64'd0, HALF);

        // Reset during ACCUM aborts without done; prior act_out was 0, so load a nonzero one first
        run_job(8'd8, 8'd8, 64'h0000_0003_0000_0000, 32'd0, 32'd0, 32'd0, 32'd0,
                0, 64'h0000_0003_0000_0000, 64'h0000_0000_F000_0000);
        do_start(8'd1, 8'd1, ONE);
        send_beat(32'h0001_0000, 32'h0001_0000, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("abort_act", bus.act_out, 64'd0);
        check("abort_sig", bus.sig_out, 64'd0);
        repeat (10) @(negedge clk);

        // Recovery after abort
        run_job(8'd2, 8'd9, 64'd0, 32'h0001_0000, 32'hFFFF_0000, 32'd0, 32'd0,
                2, 64'hFFFF_FFFF_0000_0000, 64'h0000_0000_4000_0000);

        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
